// File: rtl/cmd_router.sv
// cmd_router: routes host byte-link packets to slave strobes and frames slave messages back to the host
//
// Packet format (both directions): SYNC_BYTE, ADDR, LEN, then LEN payload bytes.
//
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   rx_data/valid    host bytes in, one-cycle strobe, no backpressure
//   tx_data/valid    host bytes out, tx_valid held until tx_ready
//   tx_ready         host link accepts the byte on tx_valid & tx_ready
//   master_data      last payload byte delivered to the slaves
//   valid_bus        one-hot strobe naming the slave that takes master_data
//   rdreq_bus        show-ahead read acknowledge, pulses on each drained byte
//   have_msg_bus     per-slave message pending
//   slave_data_bus   per-slave current byte, slave i at [8i+7:8i]
//   len_bus          per-slave message length, slave i at [8i+7:8i]
//   err_sync         pulse: stray byte outside a packet (or inter-byte timeout)
//   err_addr         pulse: packet addressed to a nonexistent slave
//
// Optional build macro CMD_TIMEOUT_EN: adds the TIMEOUT_CYC parameter and an
// inter-byte timeout that abandons a partial rx packet.
module cmd_router #(
  parameter int N_SLAVES = 9,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              master_data,
  output logic [N_SLAVES-1:0]     valid_bus,
  output logic [N_SLAVES-1:0]     rdreq_bus,
  input  logic [N_SLAVES-1:0]     have_msg_bus,
  input  logic [8*N_SLAVES-1:0]   slave_data_bus,
  input  logic [8*N_SLAVES-1:0]   len_bus,
  output logic                    err_sync,
  output logic                    err_addr
);
  localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_LEN, R_DATA} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_SYNC, T_ADDR, T_LEN, T_DATA} tx_state_t;
  rx_state_t r_q, r_d;
  logic [7:0] addr_q, addr_d, cnt_q, cnt_d;
  logic disc_q, disc_d;
  logic [7:0] master_data_q, master_data_d;
  logic [N_SLAVES-1:0] valid_bus_q, valid_bus_d;
  logic err_sync_q, err_sync_d, err_addr_q, err_addr_d;
  tx_state_t t_q, t_d;
  logic [7:0] idx_q, idx_d, len_q, len_d, ptr_q, ptr_d, tx_byte_q, tx_byte_d, gnt, nxt;
  logic tx_valid_q, tx_valid_d, hs;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  assign master_data = master_data_q;
  assign valid_bus   = valid_bus_q;
  assign err_sync    = err_sync_q;
  assign err_addr    = err_addr_q;
  assign tx_valid    = tx_valid_q;
  // Payload bytes come straight from the slave's show-ahead output so no extra read latency is needed.
  assign tx_data     = (t_q == T_DATA) ? slave_data_bus[{idx_q[3:0], 3'b000} +: 8] : tx_byte_q;
  assign hs          = tx_valid_q & tx_ready;
  assign nxt         = (idx_q == 8'(N_SLAVES - 1)) ? 8'd0 : idx_q + 8'd1;
  always_comb begin
    r_d = r_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    disc_d = disc_q;
    master_data_d = master_data_q;
    valid_bus_d = '0;
    err_sync_d = 1'b0;
    err_addr_d = 1'b0;
    if (rx_valid) begin
      case (r_q)
        R_IDLE: begin
          r_d = (rx_data == SYNC_BYTE) ? R_ADDR : R_IDLE;
          err_sync_d = rx_data != SYNC_BYTE;
        end
        R_ADDR: begin
          addr_d = rx_data;
          disc_d = rx_data >= 8'(N_SLAVES);
          err_addr_d = rx_data >= 8'(N_SLAVES);
          r_d = R_LEN;
        end
        R_LEN: begin
          cnt_d = rx_data;
          r_d = (rx_data == 8'd0) ? R_IDLE : R_DATA;
        end
        default: begin
          master_data_d = rx_data;
          valid_bus_d = disc_q ? '0 : N_SLAVES'(1) << addr_q;
          cnt_d = cnt_q - 8'd1;
          r_d = (cnt_q == 8'd1) ? R_IDLE : R_DATA;
        end
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    tmo_d = (rx_valid || r_q == R_IDLE) ? '0 : tmo_q + 1'b1;
    if (!rx_valid && r_q != R_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      r_d = R_IDLE;
      err_sync_d = 1'b1;
      tmo_d = '0;
    end
`endif
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q <= R_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      disc_q <= 1'b0;
      master_data_q <= '0;
      valid_bus_q <= '0;
      err_sync_q <= 1'b0;
      err_addr_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      r_q <= r_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
      master_data_q <= master_data_d;
      valid_bus_q <= valid_bus_d;
      err_sync_q <= err_sync_d;
      err_addr_q <= err_addr_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  // Round robin: scanning offsets downward lets the smallest offset from ptr win.
  always_comb begin
    gnt = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N_SLAVES) j = j - N_SLAVES;
      if (have_msg_bus[IW'(j)]) gnt = 8'(j);
    end
  end
  always_comb begin
    t_d = t_q;
    idx_d = idx_q;
    len_d = len_q;
    ptr_d = ptr_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d = tx_byte_q;
    rdreq_bus = '0;
    case (t_q)
      T_IDLE: begin
        if (|have_msg_bus) begin
          idx_d = gnt;
          len_d = len_bus[{gnt[3:0], 3'b000} +: 8];
          tx_byte_d = SYNC_BYTE;
          tx_valid_d = 1'b1;
          t_d = T_SYNC;
        end
      end
      T_SYNC: begin
        if (hs) begin
          tx_byte_d = idx_q;
          t_d = T_ADDR;
        end
      end
      T_ADDR: begin
        if (hs) begin
          tx_byte_d = len_q;
          t_d = T_LEN;
        end
      end
      T_LEN: begin
        if (hs) begin
          t_d = (len_q == 8'd0) ? T_IDLE : T_DATA;
          tx_valid_d = len_q != 8'd0;
          ptr_d = (len_q == 8'd0) ? nxt : ptr_q;
        end
      end
      default: begin
        if (hs) begin
          rdreq_bus = N_SLAVES'(1) << idx_q;
          len_d = len_q - 8'd1;
          t_d = (len_q == 8'd1) ? T_IDLE : T_DATA;
          tx_valid_d = len_q != 8'd1;
          ptr_d = (len_q == 8'd1) ? nxt : ptr_q;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      t_q <= T_IDLE;
      idx_q <= '0;
      len_q <= '0;
      ptr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      t_q <= t_d;
      idx_q <= idx_d;
      len_q <= len_d;
      ptr_q <= ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q <= tx_byte_d;
    end
  end
endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: scoreboard bench for cmd_router rx delivery, tx framing and error pulses
module tb_cmd_router;
  localparam int N = 9;
  typedef struct packed {logic [7:0] d; logic [N-1:0] vb;} rx_exp_t;
  typedef struct packed {logic [7:0] d; logic [N-1:0] rd;} tx_exp_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] master_data;
  logic [N-1:0] valid_bus, rdreq_bus, have_msg_bus;
  logic [8*N-1:0] slave_data_bus, len_bus;
  logic err_sync, err_addr;
  logic [7:0] rp [N];
  logic [N-1:0] armed;
  logic reload, tog;
  logic phase = 1'b0;
  rx_exp_t rxq[$];
  tx_exp_t txq[$];
  int checks = 0, errors = 0;
  int exp_es = 0, exp_ea = 0, got_es = 0, got_ea = 0;
  logic stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;
  cmd_router #(
    .N_SLAVES(N),
    .SYNC_BYTE(8'hAA)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .master_data(master_data), .valid_bus(valid_bus), .rdreq_bus(rdreq_bus),
    .have_msg_bus(have_msg_bus), .slave_data_bus(slave_data_bus), .len_bus(len_bus),
    .err_sync(err_sync), .err_addr(err_addr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) phase <= ~phase;
  assign tx_ready = tog ? phase : 1'b1;
  // Slave model: show-ahead message of bytes i*16, i*16+1, ...; slave 2 has 2 bytes, slave 5 has 1.
  always @(posedge clk)
    for (int i = 0; i < N; i++) rp[i] <= reload ? 8'd0 : rp[i] + 8'(rdreq_bus[i]);
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slave_data_bus[8*i +: 8] = 8'(i * 16) + rp[i];
      len_bus[8*i +: 8] = (i == 2) ? 8'd2 : (i == 5) ? 8'd1 : 8'd0;
      have_msg_bus[i] = armed[i] && (rp[i] < len_bus[8*i +: 8]);
    end
  end
  always @(negedge clk) begin
    if (n_rst) begin
      if (valid_bus != '0) begin
        checks++;
        if (rxq.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: valid_bus=%h master_data=%h, none expected", valid_bus, master_data);
        end else begin
          rx_exp_t e;
          e = rxq.pop_front();
          if (valid_bus !== e.vb || master_data !== e.d) begin
            errors++;
            $display("FAIL rx_deliver: got vb=%h data=%h, expected vb=%h data=%h", valid_bus, master_data, e.vb, e.d);
          end
        end
      end
      if (err_sync) got_es++;
      if (err_addr) got_ea++;
      if (tx_valid && tx_ready) begin
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: tx_data=%h, none expected", tx_data);
        end else begin
          tx_exp_t t;
          t = txq.pop_front();
          if (tx_data !== t.d || rdreq_bus !== t.rd) begin
            errors++;
            $display("FAIL tx_byte: got data=%h rdreq=%h, expected data=%h rdreq=%h", tx_data, rdreq_bus, t.d, t.rd);
          end
        end
      end else if (rdreq_bus != '0) begin
        checks++;
        errors++;
        $display("FAIL rdreq_no_hs: rdreq=%h without handshake, expected 0", rdreq_bus);
      end
      if (stall_q) begin
        checks++;
        if (!tx_valid || tx_data !== stall_d) begin
          errors++;
          $display("FAIL tx_hold: got valid=%b data=%h, expected valid=1 data=%h", tx_valid, tx_data, stall_d);
        end
      end
      stall_q = tx_valid && !tx_ready;
      stall_d = tx_data;
    end
  end
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic exp_rx(input logic [7:0] d, input logic [N-1:0] vb);
    rxq.push_back({d, vb});
  endtask
  task automatic exp_tx_run();
    txq.push_back({8'hAA, 9'h000});
    txq.push_back({8'h02, 9'h000});
    txq.push_back({8'h02, 9'h000});
    txq.push_back({8'h20, 9'h004});
    txq.push_back({8'h21, 9'h004});
    txq.push_back({8'hAA, 9'h000});
    txq.push_back({8'h05, 9'h000});
    txq.push_back({8'h01, 9'h000});
    txq.push_back({8'h50, 9'h020});
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rxq.size() != 0 || txq.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (rxq.size() != 0 || txq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: rxq=%0d txq=%0d left, expected 0 0", rxq.size(), txq.size());
    end
  endtask
  initial begin
    rx_valid = 1'b0;
    rx_data = 8'h00;
    armed = '0;
    reload = 1'b1;
    tog = 1'b0;
    idle(3);
    checks++;
    if ({tx_data, tx_valid, master_data, valid_bus, rdreq_bus, err_sync, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset: tx=%h/%b md=%h vb=%h rd=%h es=%b ea=%b, expected all 0",
               tx_data, tx_valid, master_data, valid_bus, rdreq_bus, err_sync, err_addr);
    end
    n_rst = 1'b1;
    reload = 1'b0;
    idle(2);
    exp_rx(8'h05, 9'h001);
    send(8'hAA); send(8'h00); send(8'h01); send(8'h05);
    idle(3);
    exp_rx(8'h11, 9'h008); exp_rx(8'h22, 9'h008); exp_rx(8'h33, 9'h008);
    send(8'hAA); send(8'h03); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    exp_es++;
    send(8'h55);
    idle(3);
    exp_ea++;
    send(8'hAA); send(8'h0C); send(8'h02); send(8'h01); send(8'h02);
    exp_rx(8'h07, 9'h002);
    send(8'hAA); send(8'h01); send(8'h01); send(8'h07);
    idle(2);
    send(8'hAA); send(8'h04); send(8'h00);
    exp_rx(8'h3C, 9'h010);
    send(8'hAA); send(8'h04); send(8'h01); send(8'h3C);
    exp_rx(8'h77, 9'h100);
    send(8'hAA); send(8'h08); send(8'h01); send(8'h77);
    exp_ea++;
    send(8'hAA); send(8'h09); send(8'h01); send(8'h66);
    drain(50);
    exp_tx_run();
    armed = 9'h024;
    drain(200);
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
    tog = 1'b1;
    exp_tx_run();
    exp_rx(8'h5A, 9'h100);
    send(8'hAA); send(8'h08); send(8'h01); send(8'h5A);
    drain(300);
    tog = 1'b0;
    idle(3);
`ifdef CMD_TIMEOUT_EN
    send(8'hAA); send(8'h01);
    exp_es++;
    idle(20);
    exp_rx(8'h09, 9'h002);
    send(8'hAA); send(8'h01); send(8'h01); send(8'h09);
    drain(50);
`endif
    idle(3);
    checks++;
    if (got_es != exp_es) begin
      errors++;
      $display("FAIL err_sync_count: got %0d pulses, expected %0d", got_es, exp_es);
    end
    checks++;
    if (got_ea != exp_ea) begin
      errors++;
      $display("FAIL err_addr_count: got %0d pulses, expected %0d", got_ea, exp_ea);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
